// File: rtl/pcs_encoder_tx_pkg.sv
// Shared 64b/66b PCS constants: CGMII/PCS characters, block types, control masks,
// fixed blocks and TX state encoding. The decoder side uses the same definitions.
package pcs_encoder_tx_pkg;

    localparam logic [7:0] CG_START = 8'hFB;
    localparam logic [7:0] CG_TERM  = 8'hFD;
    localparam logic [7:0] CG_FSIG  = 8'h5C;
    localparam logic [7:0] CG_SEQ   = 8'h9C;
    localparam logic [7:0] CG_IDLE  = 8'h07;
    localparam logic [7:0] CG_ERROR = 8'hFE;

    localparam logic [6:0] PCS_IDLE  = 7'h00;
    localparam logic [6:0] PCS_ERROR = 7'h1E;
    localparam logic [3:0] O_SEQ     = 4'h0;
    localparam logic [3:0] O_FSIG    = 4'hF;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam logic [7:0] BTYPE_C  = 8'h1E;
    localparam logic [7:0] BTYPE_S  = 8'h78;
    localparam logic [7:0] BTYPE_OS = 8'h4B;
    localparam logic [7:0] BTYPE_T0 = 8'h87;
    localparam logic [7:0] BTYPE_T1 = 8'h99;
    localparam logic [7:0] BTYPE_T2 = 8'hAA;
    localparam logic [7:0] BTYPE_T3 = 8'hB4;
    localparam logic [7:0] BTYPE_T4 = 8'hCC;
    localparam logic [7:0] BTYPE_T5 = 8'hD2;
    localparam logic [7:0] BTYPE_T6 = 8'hE1;
    localparam logic [7:0] BTYPE_T7 = 8'hFF;

    localparam logic [7:0] RX_CTRL_S  = 8'h80;
    localparam logic [7:0] RX_CTRL_C  = 8'hFF;
    localparam logic [7:0] RX_CTRL_T0 = 8'hFF;
    localparam logic [7:0] RX_CTRL_T1 = 8'h7F;
    localparam logic [7:0] RX_CTRL_T2 = 8'h3F;
    localparam logic [7:0] RX_CTRL_T3 = 8'h1F;
    localparam logic [7:0] RX_CTRL_T4 = 8'h0F;
    localparam logic [7:0] RX_CTRL_T5 = 8'h07;
    localparam logic [7:0] RX_CTRL_T6 = 8'h03;
    localparam logic [7:0] RX_CTRL_T7 = 8'h01;

    localparam logic [65:0] LBLOCK = {SH_CTRL, 64'h4B00000100000000};
    localparam logic [65:0] EBLOCK = {SH_CTRL, 64'h1E3C78F1E3C78F1E};

    localparam logic [3:0] TT_D = 4'b1000;
    localparam logic [3:0] TT_S = 4'b0100;
    localparam logic [3:0] TT_C = 4'b0010;
    localparam logic [3:0] TT_T = 4'b0001;
    localparam logic [3:0] TT_E = 4'b0000;

    typedef enum logic [2:0] {
        TX_INIT = 3'd0,
        TX_C    = 3'd1,
        TX_D    = 3'd2,
        TX_T    = 3'd3,
        TX_E    = 3'd4
    } tx_state_e;

    function automatic logic [7:0] btype_t(input int n);
        case (n)
            0:       return BTYPE_T0;
            1:       return BTYPE_T1;
            2:       return BTYPE_T2;
            3:       return BTYPE_T3;
            4:       return BTYPE_T4;
            5:       return BTYPE_T5;
            6:       return BTYPE_T6;
            default: return BTYPE_T7;
        endcase
    endfunction

    function automatic logic [7:0] rx_ctrl_t(input int n);
        case (n)
            0:       return RX_CTRL_T0;
            1:       return RX_CTRL_T1;
            2:       return RX_CTRL_T2;
            3:       return RX_CTRL_T3;
            4:       return RX_CTRL_T4;
            5:       return RX_CTRL_T5;
            6:       return RX_CTRL_T6;
            default: return RX_CTRL_T7;
        endcase
    endfunction

endpackage

// File: rtl/pcs_encoder_tx_block_formatter.sv
// Combinational classifier/encoder: one CGMII word in, its {D,S,C,T} class and
// 66-bit coded block out. Unrecognised words come back as class E with EBLOCK.
module pcs_tx_block_formatter
    import pcs_encoder_tx_pkg::*;
(
    input  logic [63:0] tx_data_i,
    input  logic [7:0]  tx_ctrl_i,
    output logic [3:0]  class_o,
    output logic [65:0] coded_o
);

    logic [7:0]  byte_w [8];
    logic [6:0]  pcs_w  [8];
    logic [7:0]  ic_w;
    logic        t_hit;
    logic        tail_ok;
    int          t_n;
    logic [55:0] pay_c;
    logic [55:0] pay_t;

    // Byte 0 sits in the top lane; ic_w[k] marks byte k as IDLE or ERROR.
    always_comb begin
        ic_w = '0;
        for (int k = 0; k < 8; k++) begin
            byte_w[k] = tx_data_i[63-8*k -: 8];
            ic_w[k]   = (byte_w[k] == CG_IDLE) || (byte_w[k] == CG_ERROR);
            pcs_w[k]  = (byte_w[k] == CG_ERROR) ? PCS_ERROR : PCS_IDLE;
        end
    end

    always_comb begin
        t_hit   = 1'b0;
        t_n     = 0;
        tail_ok = 1'b1;
        pay_c   = '0;
        pay_t   = '0;
        class_o = TT_E;
        coded_o = EBLOCK;

        for (int n = 0; n < 8; n++) begin
            tail_ok = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (k > n) tail_ok = tail_ok & ic_w[k];
            end
            if (!t_hit && (tx_ctrl_i == rx_ctrl_t(n)) && (byte_w[n] == CG_TERM) && tail_ok) begin
                t_hit = 1'b1;
                t_n   = n;
            end
        end

        // Control code k lands at the same 7-bit slot in both C and T blocks;
        // the zero pad in T blocks is whatever the data bytes leave unfilled.
        for (int k = 0; k < 8; k++) pay_c[55-7*k -: 7] = pcs_w[k];
        for (int k = 0; k < 7; k++) if (k < t_n) pay_t[55-8*k -: 8] = byte_w[k];
        for (int k = 1; k < 8; k++) if (k > t_n) pay_t[55-7*k -: 7] = pcs_w[k];

        if (tx_ctrl_i == 8'h00) begin
            class_o = TT_D;
            coded_o = {SH_DATA, tx_data_i};
        end else if ((tx_ctrl_i == RX_CTRL_S) && (byte_w[0] == CG_START)) begin
            class_o = TT_S;
            coded_o = {SH_CTRL, BTYPE_S, tx_data_i[55:0]};
        end else if ((tx_ctrl_i == RX_CTRL_C) && (&ic_w)) begin
            class_o = TT_C;
            coded_o = {SH_CTRL, BTYPE_C, pay_c};
        end else if ((tx_ctrl_i == RX_CTRL_S) && ((byte_w[0] == CG_SEQ) || (byte_w[0] == CG_FSIG))
                     && (tx_data_i[31:0] == 32'h0)) begin
            class_o = TT_C;
            coded_o = {SH_CTRL, BTYPE_OS, tx_data_i[55:32],
                       (byte_w[0] == CG_FSIG) ? O_FSIG : O_SEQ, 28'h0};
        end else if (t_hit) begin
            class_o = TT_T;
            coded_o = {SH_CTRL, btype_t(t_n), pay_t};
        end
    end

endmodule

// File: rtl/pcs_encoder_tx.sv
// 64b/66b transmit encoder: captures a CGMII word on i_enable, then classifies it,
// runs the TX state machine and registers the coded block one cycle later.
module pcs_encoder_tx
    import pcs_encoder_tx_pkg::*;
#(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int LEN_TX_DATA     = 64,
    parameter int LEN_TX_CTRL     = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic [LEN_TX_DATA-1:0]     i_tx_data,
    input  logic [LEN_TX_CTRL-1:0]     i_tx_ctrl,
    output logic [LEN_CODED_BLOCK-1:0] o_tx_coded,
    output logic [3:0]                 o_t_type,
    output logic                       o_valid
);

    logic [LEN_TX_DATA-1:0] data_q;
    logic [LEN_TX_CTRL-1:0] ctrl_q;
    logic                   cap_q;
    tx_state_e              state_q;
    tx_state_e              state_d;
    logic [3:0]             cls_w;
    logic [65:0]            blk_w;

    pcs_tx_block_formatter u_formatter (
        .tx_data_i (data_q),
        .tx_ctrl_i (ctrl_q),
        .class_o   (cls_w),
        .coded_o   (blk_w)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_INIT: begin
                if (cls_w == TT_C)      state_d = TX_C;
                else if (cls_w == TT_S) state_d = TX_D;
            end
            TX_C, TX_T: begin
                if (cls_w == TT_C)      state_d = TX_C;
                else if (cls_w == TT_S) state_d = TX_D;
                else                    state_d = TX_E;
            end
            TX_D: begin
                if (cls_w == TT_D)      state_d = TX_D;
                else if (cls_w == TT_T) state_d = TX_T;
                else                    state_d = TX_E;
            end
            TX_E: begin
                if (cls_w == TT_C)      state_d = TX_C;
                else if (cls_w == TT_D) state_d = TX_D;
                else if (cls_w == TT_T) state_d = TX_T;
                else                    state_d = TX_E;
            end
            default: state_d = TX_INIT;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            data_q     <= '0;
            ctrl_q     <= '0;
            cap_q      <= 1'b0;
            state_q    <= TX_INIT;
            o_tx_coded <= LBLOCK;
            o_t_type   <= TT_E;
            o_valid    <= 1'b0;
        end else begin
            // Stage 1: capture the CGMII word.
            cap_q <= i_enable;
            if (i_enable) begin
                data_q <= i_tx_data;
                ctrl_q <= i_tx_ctrl;
            end
            // Stage 2: advance the FSM and register the coded block.
            o_valid <= cap_q;
            if (cap_q) begin
                state_q  <= state_d;
                o_t_type <= cls_w;
                if (state_d == TX_E)
                    o_tx_coded <= EBLOCK;
                else if ((state_q == TX_INIT) && (state_d == TX_INIT))
                    o_tx_coded <= LBLOCK;
                else
                    o_tx_coded <= blk_w;
            end
        end
    end

endmodule

// File: tb/tb_pcs_encoder_tx.sv
// Bench for pcs_encoder_tx: fixed vector table, hand sequences and a randomized
// run checked every cycle against a word-level reference model.
module tb_pcs_encoder_tx;

    localparam logic [65:0] LB  = {2'b10, 64'h4B00000100000000};
    localparam logic [65:0] EB  = {2'b10, 64'h1E3C78F1E3C78F1E};
    localparam logic [65:0] IDL = {2'b10, 64'h1E00000000000000};

    logic        clk = 1'b0;
    logic        i_reset, i_enable;
    logic [63:0] i_tx_data;
    logic [7:0]  i_tx_ctrl;
    logic [65:0] o_tx_coded;
    logic [3:0]  o_t_type;
    logic        o_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pcs_encoder_tx dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_tx_data  (i_tx_data),
        .i_tx_ctrl  (i_tx_ctrl),
        .o_tx_coded (o_tx_coded),
        .o_t_type   (o_t_type),
        .o_valid    (o_valid)
    );

    logic [7:0] BT [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    // Next state by [state][class]; states INIT,C,D,T,E = 0..4, classes D,S,C,T,E = 0..4.
    int NXT [5][5] = '{'{0, 2, 1, 0, 0},
                       '{4, 2, 1, 4, 4},
                       '{2, 4, 4, 3, 4},
                       '{4, 2, 1, 4, 4},
                       '{2, 4, 1, 3, 4}};

    int          m_state = 0;
    logic        m_pend  = 1'b0;
    logic [63:0] m_d     = '0;
    logic [7:0]  m_c     = '0;
    logic [65:0] e_coded = LB;
    logic [3:0]  e_tt    = 4'b0000;
    logic        e_valid = 1'b0;

    function automatic logic is_ie(input logic [7:0] b);
        return (b == 8'h07) || (b == 8'hFE);
    endfunction

    function automatic logic [6:0] pcs7(input logic [7:0] b);
        return (b == 8'hFE) ? 7'h1E : 7'h00;
    endfunction

    function automatic logic [3:0] ref_class(input logic [63:0] d, input logic [7:0] c,
                                              output logic [65:0] blk);
        logic [7:0]  by [8];
        logic [63:0] acc;
        logic        ok;
        int          nlead;
        for (int i = 0; i < 8; i++) by[i] = 8'(d >> (56 - 8*i));
        blk = EB;
        if (c == 8'h00) begin
            blk = {2'b01, d};
            return 4'b1000;
        end
        if (c == 8'h80 && by[0] == 8'hFB) begin
            blk = {2'b10, 8'h78, d[55:0]};
            return 4'b0100;
        end
        if (c == 8'hFF) begin
            ok = 1'b1; acc = '0;
            for (int i = 0; i < 8; i++) begin
                ok  = ok & is_ie(by[i]);
                acc = (acc << 7) | 64'(pcs7(by[i]));
            end
            if (ok) begin
                blk = {2'b10, 8'h1E, acc[55:0]};
                return 4'b0010;
            end
        end
        if (c == 8'h80 && (by[0] == 8'h9C || by[0] == 8'h5C) && d[31:0] == 32'h0) begin
            blk = {2'b10, 8'h4B, d[55:32], ((by[0] == 8'h5C) ? 4'hF : 4'h0), 28'h0};
            return 4'b0010;
        end
        nlead = 0;
        while (nlead < 8 && !c[7-nlead]) nlead++;
        if (nlead < 8 && c == (8'hFF >> nlead) && by[nlead] == 8'hFD) begin
            ok = 1'b1; acc = '0;
            for (int i = 0; i < nlead; i++) acc = (acc << 8) | 64'(by[i]);
            acc = acc << (7 - nlead);
            for (int i = nlead + 1; i < 8; i++) begin
                ok  = ok & is_ie(by[i]);
                acc = (acc << 7) | 64'(pcs7(by[i]));
            end
            if (ok) begin
                blk = {2'b10, BT[nlead], acc[55:0]};
                return 4'b0001;
            end
        end
        return 4'b0000;
    endfunction

    function automatic int cidx(input logic [3:0] cls);
        case (cls)
            4'b1000: return 0;
            4'b0100: return 1;
            4'b0010: return 2;
            4'b0001: return 3;
            default: return 4;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [63:0] d, input logic [7:0] c);
        logic [65:0] blk;
        logic [3:0]  cls;
        int          ns;
        if (r) begin
            m_state = 0; m_pend = 1'b0; m_d = '0; m_c = '0;
            e_coded = LB; e_tt = 4'b0000; e_valid = 1'b0;
        end else begin
            e_valid = m_pend;
            if (m_pend) begin
                cls  = ref_class(m_d, m_c, blk);
                ns   = NXT[m_state][cidx(cls)];
                e_tt = cls;
                if (ns == 4)                     e_coded = EB;
                else if (m_state == 0 && ns == 0) e_coded = LB;
                else                              e_coded = blk;
                m_state = ns;
            end
            m_pend = e;
            if (e) begin
                m_d = d; m_c = c;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic cyc(input logic r, input logic e, input logic [63:0] d, input logic [7:0] c);
        i_reset = r; i_enable = e; i_tx_data = d; i_tx_ctrl = c;
        @(posedge clk);
        model_step(r, e, d, c);
        #1;
        chk("model_coded", o_tx_coded, e_coded);
        chk("model_ttype", 66'(o_t_type), 66'(e_tt));
        chk("model_valid", 66'(o_valid), 66'(e_valid));
    endtask

    task automatic rand_word(output logic [63:0] d, output logic [7:0] c);
        logic [7:0] by [8];
        int kind, n;
        kind = int'($urandom_range(0, 7));
        for (int i = 0; i < 8; i++) by[i] = 8'($urandom);
        c = 8'h00;
        case (kind)
            0, 1: c = 8'h00;
            2: begin by[0] = 8'hFB; c = 8'h80; end
            3: begin
                for (int i = 0; i < 8; i++)
                    if ($urandom_range(0, 15) != 0) by[i] = $urandom_range(0, 1) ? 8'h07 : 8'hFE;
                c = 8'hFF;
            end
            4: begin
                by[0] = $urandom_range(0, 1) ? 8'h9C : 8'h5C;
                if ($urandom_range(0, 7) != 0) for (int i = 4; i < 8; i++) by[i] = 8'h00;
                c = 8'h80;
            end
            5, 6: begin
                n = int'($urandom_range(0, 7));
                by[n] = 8'hFD;
                for (int i = n + 1; i < 8; i++)
                    if ($urandom_range(0, 15) != 0) by[i] = $urandom_range(0, 1) ? 8'h07 : 8'hFE;
                c = 8'hFF >> n;
            end
            default: c = 8'($urandom);
        endcase
        d = '0;
        for (int i = 0; i < 8; i++) d = {d[55:0], by[i]};
    endtask

    typedef struct {
        logic        rst;
        logic [63:0] d;
        logic [7:0]  c;
        logic [65:0] coded;
        logic [3:0]  tt;
    } vec_t;

    vec_t tv [19];

    initial begin
        logic [63:0] rd;
        logic [7:0]  rc;

        tv[0]  = '{1'b1, 64'h0707070707070707, 8'hFF, IDL,                             4'b0010};
        tv[1]  = '{1'b0, 64'hFB555555555555D5, 8'h80, {2'b10, 64'h78555555555555D5}, 4'b0100};
        tv[2]  = '{1'b0, 64'h0011223344556677, 8'h00, {2'b01, 64'h0011223344556677}, 4'b1000};
        tv[3]  = '{1'b0, 64'hAABBCCFD07070707, 8'h1F, {2'b10, 64'hB4AABBCC00000000}, 4'b0001};
        tv[4]  = '{1'b0, 64'h0707070707070707, 8'hFF, IDL,                             4'b0010};
        tv[5]  = '{1'b0, 64'h0011223344556677, 8'h00, EB,                              4'b1000};
        tv[6]  = '{1'b0, 64'h0707070707070707, 8'hFF, IDL,                             4'b0010};
        tv[7]  = '{1'b1, 64'hDEADBEEF01234567, 8'h00, LB,                              4'b1000};
        tv[8]  = '{1'b0, 64'h0123456789ABCDEF, 8'h00, LB,                              4'b1000};
        tv[9]  = '{1'b0, 64'h9C00000100000000, 8'h80, LB,                              4'b0010};
        tv[10] = '{1'b0, 64'h5C00000100000000, 8'h80, {2'b10, 64'h4B000001F0000000}, 4'b0010};
        tv[11] = '{1'b0, 64'hFB11111111111111, 8'h80, {2'b10, 64'h7811111111111111}, 4'b0100};
        tv[12] = '{1'b0, 64'h0123456789ABCDEF, 8'h00, {2'b01, 64'h0123456789ABCDEF}, 4'b1000};
        tv[13] = '{1'b0, 64'hFD07070707070707, 8'hFF, {2'b10, 64'h8700000000000000}, 4'b0001};
        tv[14] = '{1'b0, 64'hFD07070707550707, 8'hFF, EB,                              4'b0000};
        tv[15] = '{1'b0, 64'h07FE070707070707, 8'hFF, {2'b10, 64'h1E00780000000000}, 4'b0010};
        tv[16] = '{1'b0, 64'hFB22222222222222, 8'h80, {2'b10, 64'h7822222222222222}, 4'b0100};
        tv[17] = '{1'b0, 64'h1122334455FD07FE, 8'h07, {2'b10, 64'hD21122334455001E}, 4'b0001};
        tv[18] = '{1'b0, 64'h0707073C07070707, 8'hFF, EB,                              4'b0000};

        cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, '0, '0);
        chk("reset_coded", o_tx_coded, LB);
        chk("reset_ttype", 66'(o_t_type), 66'(4'b0000));
        chk("reset_valid", 66'(o_valid), 66'(1'b0));

        // Table: one enabled word, one idle cycle, then the word's result is on the outputs.
        for (int i = 0; i < 19; i++) begin
            if (tv[i].rst) cyc(1'b1, 1'b0, '0, '0);
            cyc(1'b0, 1'b1, tv[i].d, tv[i].c);
            cyc(1'b0, 1'b0, '0, '0);
            chk($sformatf("vec%0d_coded", i), o_tx_coded, tv[i].coded);
            chk($sformatf("vec%0d_ttype", i), 66'(o_t_type), 66'(tv[i].tt));
            chk($sformatf("vec%0d_valid", i), 66'(o_valid), 66'(1'b1));
        end

        // Back-to-back frame with i_enable held high.
        cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 64'h0707070707070707, 8'hFF);
        cyc(1'b0, 1'b1, 64'hFB555555555555D5, 8'h80);
        chk("strm_idle", o_tx_coded, IDL);
        cyc(1'b0, 1'b1, 64'h0011223344556677, 8'h00);
        chk("strm_start", o_tx_coded, {2'b10, 64'h78555555555555D5});
        cyc(1'b0, 1'b1, 64'hAABBCCFD07070707, 8'h1F);
        chk("strm_data", o_tx_coded, {2'b01, 64'h0011223344556677});
        cyc(1'b0, 1'b0, '0, '0);
        chk("strm_term", o_tx_coded, {2'b10, 64'hB4AABBCC00000000});
        chk("strm_term_vld", 66'(o_valid), 66'(1'b1));
        cyc(1'b0, 1'b0, '0, '0);
        chk("strm_gap_vld", 66'(o_valid), 66'(1'b0));

        // Enable gap mid-frame, then reset during TX_D with enable also high.
        cyc(1'b0, 1'b1, 64'h0707070707070707, 8'hFF);
        cyc(1'b0, 1'b1, 64'hFB00000000000000, 8'h80);
        cyc(1'b0, 1'b1, 64'h1111111111111111, 8'h00);
        cyc(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
            chk("hold_coded", o_tx_coded, {2'b01, 64'h1111111111111111});
            chk("hold_valid", 66'(o_valid), 66'(1'b0));
        end
        cyc(1'b0, 1'b1, 64'h2222222222222222, 8'h00);
        cyc(1'b0, 1'b0, '0, '0);
        chk("resume_data", o_tx_coded, {2'b01, 64'h2222222222222222});
        cyc(1'b1, 1'b1, 64'h3333333333333333, 8'h00);
        chk("midrst_coded", o_tx_coded, LB);
        chk("midrst_ttype", 66'(o_t_type), 66'(4'b0000));
        chk("midrst_valid", 66'(o_valid), 66'(1'b0));
        cyc(1'b0, 1'b0, '0, '0);
        chk("midrst_nocap", 66'(o_valid), 66'(1'b0));
        cyc(1'b0, 1'b1, 64'h4444444444444444, 8'h00);
        cyc(1'b0, 1'b0, '0, '0);
        chk("postrst_d", o_tx_coded, LB);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            rand_word(rd, rc);
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), rd, rc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
